risc_ctrl_seq: RTL

//  Phase sequencer for the 8-bit RISC core. Drives the program counter (pclk strobe, ldpc),
//  the instruction register, memory and accumulator once per instruction.

---
 rtl/risc_ctrl_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/risc_ctrl_seq.sv
// Phase sequencer for the 8-bit RISC core: one pass of eight phases per instruction, with memory wait states.
// Optional single-step gate is built when RISC_CTRL_STEP_EN is defined.
module risc_ctrl_seq #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef RISC_CTRL_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       pclk,
    output logic       ldpc,
    output logic       wr,
    output logic       ld_ac,
    output logic       data_e,
    output logic [2:0] phase
);

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8,
        S_STEP_WAIT  = 4'd9
    } state_t;

    localparam logic [2:0] WAIT_N = 3'(MEM_WAIT);
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t     r_state;
    logic [2:0] r_wait;
    logic       w_aluop;
    logic       w_jmp;
    logic       w_sto;

    assign w_aluop = (opcode >= 3'd2) && (opcode <= 3'd5);
    assign w_jmp   = (opcode == OP_JMP);
    assign w_sto   = (opcode == OP_STO);

`ifdef RISC_CTRL_STEP_EN
    logic r_step;
    logic w_step_rise;
    assign w_step_rise = step & ~r_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_step <= 1'b0;
        else     r_step <= step;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INST_ADDR;
            r_wait  <= 3'd0;
        end else begin
            case (r_state)
                S_INST_ADDR:  r_state <= S_INST_FETCH;
                S_INST_FETCH: begin
                    if (r_wait < WAIT_N) begin
                        r_wait <= r_wait + 3'd1;
                    end else begin
                        r_wait  <= 3'd0;
                        r_state <= S_INST_LOAD;
                    end
                end
                S_INST_LOAD:  r_state <= S_IDLE;
                S_IDLE:       r_state <= S_OP_ADDR;
                S_OP_ADDR:    r_state <= (opcode == OP_HLT) ? S_HALTED : S_OP_FETCH;
                S_OP_FETCH: begin
                    // Only ALU operands actually read memory, so only they wait.
                    if (w_aluop && (r_wait < WAIT_N)) begin
                        r_wait <= r_wait + 3'd1;
                    end else begin
                        r_wait  <= 3'd0;
                        r_state <= S_ALU_OP;
                    end
                end
                S_ALU_OP:     r_state <= S_STORE;
`ifdef RISC_CTRL_STEP_EN
                S_STORE:      r_state <= S_STEP_WAIT;
                S_STEP_WAIT:  if (w_step_rise) r_state <= S_INST_ADDR;
`else
                S_STORE:      r_state <= S_INST_ADDR;
                S_STEP_WAIT:  r_state <= S_INST_ADDR;
`endif
                S_HALTED:     r_state <= S_HALTED;
                default:      r_state <= S_INST_ADDR;
            endcase
        end
    end

    // Outputs depend on the live opcode/zero, so they decode from the state register rather than being registered.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        pclk   = 1'b0;
        ldpc   = 1'b0;
        wr     = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        phase  = 3'd7;
        case (r_state)
            S_INST_ADDR:  begin phase = 3'd0; sel = 1'b1; end
            S_INST_FETCH: begin phase = 3'd1; sel = 1'b1; rd = 1'b1; end
            S_INST_LOAD:  begin phase = 3'd2; sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
            S_IDLE:       begin phase = 3'd3; sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
            S_OP_ADDR:    begin phase = 3'd4; pclk = 1'b1; halt = (opcode == OP_HLT); end
            S_OP_FETCH:   begin phase = 3'd5; rd = w_aluop; end
            S_ALU_OP: begin
                phase  = 3'd6;
                rd     = w_aluop;
                pclk   = (opcode == OP_SKZ) && zero;
                ldpc   = w_jmp;
                data_e = w_sto;
            end
            S_STORE: begin
                phase  = 3'd7;
                rd     = w_aluop;
                ld_ac  = w_aluop;
                pclk   = w_jmp;
                ldpc   = w_jmp;
                wr     = w_sto;
                data_e = w_sto;
            end
            S_HALTED:     halt = 1'b1;
            S_STEP_WAIT:  sel  = 1'b1;
            default:      phase = 3'd7;
        endcase
    end

endmodule
